// File: rtl/puf_resp_deser.sv
// Deserialises one PUF response (32/64/128 bits, LSB-first) into 32-bit words behind a FWFT FIFO.
// Optional macro PUF_RESP_HW_EN adds hw_o, the Hamming weight of the current response.
module puf_resp_deser #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [1:0]              length,
  input  logic                    bit_i,
  input  logic                    bit_valid_i,
  output logic [WORD_W-1:0]       word_o,
  output logic                    word_valid_o,
  input  logic                    word_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overflow_o,
  output logic [$clog2(DEPTH):0]  fill_o
`ifdef PUF_RESP_HW_EN
  ,
  output logic [7:0]              hw_o
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t            state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [6:0]        last_q, last_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [PW:0]       fill_q;

  logic              push, pop, full, push_ok;
  logic [WORD_W-1:0] push_word;

  // The completed word is the shift register with the incoming bit in position 31.
  assign push_word = {bit_i, shift_q[WORD_W-2:0]};
  assign pop       = word_valid_o && word_ready_i;
  assign full      = (fill_q == (PW+1)'(DEPTH));
  assign push_ok   = push && (!full || pop);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
          cnt_d   = '0;
          shift_d = '0;
          ovf_d   = 1'b0;
          last_d  = (length == 2'b00) ? 7'd31 : (length == 2'b01) ? 7'd63 : 7'd127;
        end
      end
      CAPTURE: begin
        if (bit_valid_i) begin
          shift_d[cnt_q[4:0]] = bit_i;
          cnt_d               = cnt_q + 7'd1;
          push                = (cnt_q[4:0] == 5'd31);
          if (cnt_q == last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A dropped word never blocks capture; it only marks the sticky flag.
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      if (push_ok && !pop)      fill_q <= fill_q + 1'b1;
      else if (!push_ok && pop) fill_q <= fill_q - 1'b1;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_word;
  end

  assign word_valid_o = (fill_q != '0);
  assign word_o       = word_valid_o ? mem_q[rd_q] : '0;
  assign busy_o       = (state_q == CAPTURE);
  assign done_o       = done_q;
  assign overflow_o   = ovf_q;
  assign fill_o       = fill_q;

`ifdef PUF_RESP_HW_EN
  logic [7:0] hw_q;

  always_ff @(posedge clk) begin
    if (!rstn)                                  hw_q <= '0;
    else if (state_q == IDLE && start)          hw_q <= '0;
    else if (state_q == CAPTURE && bit_valid_i && bit_i) hw_q <= hw_q + 8'd1;
  end

  assign hw_o = hw_q;
`endif

endmodule

// File: tb/tb_puf_resp_deser.sv
// Self-checking bench for puf_resp_deser: directed steps plus random traffic against a queue-based model.
// Checks hw_o as well when PUF_RESP_HW_EN is defined.
module tb_puf_resp_deser;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [1:0]  length;
  logic        bit_i;
  logic        bit_valid_i;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        overflow_o;
  logic [2:0]  fill_o;
`ifdef PUF_RESP_HW_EN
  logic [7:0]  hw_o;
`endif

  always #5 clk = ~clk;

  puf_resp_deser #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .length       (length),
    .bit_i        (bit_i),
    .bit_valid_i  (bit_valid_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overflow_o   (overflow_o),
    .fill_o       (fill_o)
`ifdef PUF_RESP_HW_EN
    ,
    .hw_o         (hw_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the response as a list of bits, the FIFO as a list of words.
  bit          mCap;
  int          mTarget;
  bit          mBits[$];
  logic [31:0] mFifo[$];
  bit          mOvf;
  bit          mDone;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int modelWeight();
    int n = 0;
    foreach (mBits[i]) n += mBits[i];
    return n;
  endfunction

  task automatic modelStep();
    bit          pop;
    bit          doPush;
    logic [31:0] w;
    doPush = 1'b0;
    w      = '0;
    if (!rstn) begin
      mCap = 1'b0; mBits.delete(); mFifo.delete(); mOvf = 1'b0; mDone = 1'b0;
      return;
    end
    pop   = (mFifo.size() > 0) && word_ready_i;
    mDone = 1'b0;
    if (mCap) begin
      if (bit_valid_i) begin
        mBits.push_back(bit_i);
        if (mBits.size() % 32 == 0) begin
          doPush = 1'b1;
          for (int j = 0; j < 32; j++) w[j] = mBits[mBits.size() - 32 + j];
        end
        if (mBits.size() == mTarget) begin
          mDone = 1'b1;
          mCap  = 1'b0;
        end
      end
    end else if (start) begin
      mCap    = 1'b1;
      mTarget = 32 << ((length > 2'd1) ? 2 : int'(length));
      mBits.delete();
      mOvf    = 1'b0;
    end
    if (pop) void'(mFifo.pop_front());
    if (doPush) begin
      if (mFifo.size() >= DEPTH) mOvf = 1'b1;
      else mFifo.push_back(w);
    end
  endtask

  task automatic checkOutput();
    checkEq("word_o",       word_o,       (mFifo.size() > 0) ? mFifo[0] : 32'h0);
    checkEq("word_valid_o", word_valid_o, mFifo.size() > 0);
    checkEq("busy_o",       busy_o,       mCap);
    checkEq("done_o",       done_o,       mDone);
    checkEq("overflow_o",   overflow_o,   mOvf);
    checkEq("fill_o",       fill_o,       mFifo.size());
`ifdef PUF_RESP_HW_EN
    checkEq("hw_o",         hw_o,         mCap || mDone || !rstn ? modelWeight() : modelWeight());
`endif
  endtask

  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic pulseStart(input logic [1:0] len);
    start = 1'b1; length = len;
    applyStimulus();
    start = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 32; i++) begin
      bit_i = w[i]; bit_valid_i = 1'b1;
      applyStimulus();
      if (gaps) begin
        bit_valid_i = 1'b0; bit_i = $urandom_range(0, 1);
        applyStimulus();
      end
    end
    bit_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  logic [31:0] w0;

  initial begin
    rstn = 1'b0; start = 1'b0; length = 2'b00; bit_i = 1'b0;
    bit_valid_i = 1'b0; word_ready_i = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(1);

    // 32-bit response drained immediately
    word_ready_i = 1'b1;
    pulseStart(2'b00);
    sendWord(32'hA5A5_1234, 1'b0);
    idle(2);
    checkEq("fill_after_32", fill_o, 3'd0);

    // 128 bits with consumer stalled, then drain in order
    word_ready_i = 1'b0;
    pulseStart(2'b10);
    for (int k = 0; k < 4; k++) sendWord($urandom, 1'b0);
    idle(1);
    checkEq("fill_full", fill_o, 3'd4);
    checkEq("no_ovf", overflow_o, 1'b0);
    word_ready_i = 1'b1;
    idle(6);

    // Two 128-bit responses without popping overflow the FIFO
    word_ready_i = 1'b0;
    pulseStart(2'b11);
    for (int k = 0; k < 4; k++) sendWord($urandom, 1'b0);
    pulseStart(2'b10);
    for (int k = 0; k < 4; k++) sendWord($urandom, 1'b0);
    idle(1);
    checkEq("ovf_set", overflow_o, 1'b1);
    pulseStart(2'b00);
    checkEq("ovf_cleared", overflow_o, 1'b0);
    word_ready_i = 1'b1;
    sendWord($urandom, 1'b0);
    idle(6);

    // Gapped bits with a stray start of a different length mid-capture
    pulseStart(2'b00);
    w0 = $urandom;
    for (int i = 0; i < 32; i++) begin
      bit_i = w0[i]; bit_valid_i = 1'b1;
      applyStimulus();
      bit_valid_i = 1'b0; start = (i == 10); length = 2'b10;
      applyStimulus();
      start = 1'b0;
    end
    idle(2);

    // Reset mid-capture abandons the partial word
    pulseStart(2'b00);
    w0 = $urandom;
    for (int i = 0; i < 20; i++) begin
      bit_i = w0[i]; bit_valid_i = 1'b1;
      applyStimulus();
    end
    bit_valid_i = 1'b0; rstn = 1'b0;
    applyStimulus();
    checkEq("rst_word", word_o, 32'h0);
    checkEq("rst_busy", busy_o, 1'b0);
    rstn = 1'b1; word_ready_i = 1'b0;
    pulseStart(2'b00);
    sendWord(32'h1357_9BDF, 1'b0);
    idle(1);
    checkEq("fresh_fill", fill_o, 3'd1);
    checkEq("fresh_word", word_o, 32'h1357_9BDF);
    word_ready_i = 1'b1;
    idle(2);

`ifdef PUF_RESP_HW_EN
    // 64-bit response with 37 ones
    pulseStart(2'b01);
    sendWord(32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 32; i++) begin
      bit_i = (i < 5); bit_valid_i = 1'b1;
      applyStimulus();
    end
    bit_valid_i = 1'b0;
    checkEq("hw37_done", done_o, 1'b1);
    checkEq("hw37", hw_o, 8'd37);
    pulseStart(2'b00);
    checkEq("hw_cleared", hw_o, 8'd0);
    sendWord($urandom, 1'b0);
    idle(2);
`endif

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rstn         = ($urandom_range(0, 499) != 0);
      start        = ($urandom_range(0, 19) == 0);
      length       = 2'($urandom_range(0, 3));
      bit_i        = 1'($urandom_range(0, 1));
      bit_valid_i  = ($urandom_range(0, 3) != 0);
      word_ready_i = ($urandom_range(0, 1) == 1);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_resp_deser.md
Name: puf_resp_deser

Overview:
- Downstream consumer of the PUF core's serial response bit (`out`).
- Gathers one complete response of 32, 64 or 128 bits, selected by the same `length` code driven to the PUF core.
- Packs the response LSB-first into 32-bit words and buffers them in a small FIFO.
- A valid/ready port hands the words to the host-side logic (LA or Wishbone bridge).

Parameters:
- DEPTH, 4, FIFO depth in 32-bit words; power of two, 2..8; 4 holds one full 128-bit response.
- WORD_W, 32, packed word width; fixed at 32 and not to be overridden.

Ports:
- clk  input  1  single clock, shared with the PUF core
- rstn  input  1  synchronous active-low reset; sampled on the rising edge of clk
- start  input  1  one-cycle pulse; begins capture of a new response
- length  input  2  00=32 bits, 01=64, 10=128, 11=128; latched on an accepted start
- bit_i  input  1  serial response bit from the PUF core
- bit_valid_i  input  1  bit_i is sampled on cycles where this is high
- word_o  output  32  FIFO head word
- word_valid_o  output  1  FIFO not empty
- word_ready_i  input  1  consumer accepts word_o when word_valid_o && word_ready_i
- busy_o  output  1  high in CAPTURE state
- done_o  output  1  one-cycle pulse when the last word of a response is pushed
- overflow_o  output  1  sticky; a word was dropped because the FIFO was full
- fill_o  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rstn=0 at a clk edge):
  - State goes to IDLE.
  - FIFO is emptied; shift register and bit counter are cleared.
  - Outputs: word_o=0, word_valid_o=0, busy_o=0, done_o=0, overflow_o=0, fill_o=0.
  - Reset asserted during CAPTURE abandons the partial word; no push occurs.
- States: IDLE, CAPTURE.
  - IDLE -> CAPTURE on start=1. This latches the target total: 32 << min(length,2).
  - It also clears the bit counter and shift register. busy_o rises the next cycle.
  - start in CAPTURE is ignored; the latched length is unchanged.
- CAPTURE, each cycle with bit_valid_i=1:
  - Bit k of the response (k counts from 0) goes to shift-register bit (k mod 32), i.e. the first bit lands in word bit 0.
  - When (k mod 32)==31, the completed word is pushed to the FIFO in the same edge.
  - The word is visible on word_o the next cycle if the FIFO was empty.
- End of response:
  - When k == total-1, the last word is pushed and done_o pulses that next cycle.
  - The state returns to IDLE at the same edge.
- bit_valid_i=0 in CAPTURE: no change; gaps of any length are allowed.
- FIFO:
  - First-word fall-through. word_o is the head entry, or 0 when empty.
  - Pop on word_valid_o && word_ready_i.
  - Push and pop in the same cycle are both performed; fill_o is unchanged.
  - Full and a push without a simultaneous pop: the word is dropped and overflow_o sets.
  - Capture still continues and done_o still fires.
  - Full with a simultaneous pop: the push succeeds and there is no overflow.
  - overflow_o clears only on reset or an accepted start.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. fill_o runs 0..DEPTH.
- In IDLE, bit_i and bit_valid_i are ignored.
- Latency: last bit sampled -> word_valid_o high = 1 cycle (FIFO previously empty).

Optional Feature:
- Macro PUF_RESP_HW_EN.
- When defined:
  - Adds output hw_o, 8 bits: the Hamming weight (count of 1s) of the current response.
  - Cleared on an accepted start, incremented on each sampled bit_i=1.
  - Holds its value after done_o until the next start. Reset value is 0.
  - Maximum value is 128, so it does not saturate.
- When not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- length=00, start, 32 bits 0xA5A5_1234 LSB-first with bit_valid_i=1, word_ready_i=1:
  - word_o=0xA5A51234 with word_valid_o for 1 cycle.
  - done_o pulses once; fill_o returns to 0.
- length=10, word_ready_i=0, 128 bits forming words W0..W3:
  - fill_o=4 and overflow_o=0.
  - Raising ready then pops W0, W1, W2, W3 in order.
- length=10 twice without popping (DEPTH=4):
  - The second response's words are dropped and overflow_o=1.
  - The next start clears overflow_o.
- bit_valid_i toggled every other cycle plus a start pulse mid-capture:
  - Result is identical to the contiguous case; the second start has no effect.
- rstn=0 after 20 of 32 bits, then a fresh 32-bit capture:
  - Only the fresh word appears and fill_o=1.
  - All outputs are 0 during reset.
- PUF_RESP_HW_EN defined, length=01, 64 bits containing 37 ones:
  - hw_o=37 at done_o.
  - hw_o=0 after the next start.
